// File: rtl/result_writer_bram.sv
// Buffers 4-lane result beats in a 2-entry FIFO and serialises them as 32-bit writes on BRAM2.
// Define RESULT_WRITER_PACK8_EN to clamp and pack each beat into a single word instead.
module result_writer_bram #(
    parameter int CNT_BIT       = 31,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 12,
    parameter int IN_DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_run_i,
    input  logic [CNT_BIT-1:0] run_count_i,
    input  logic [AWIDTH-1:0]  base_addr_i,
    input  logic               result_valid_i,
    output logic               result_ready_o,
    input  logic [DWIDTH-1:0]  result_0_i,
    input  logic [DWIDTH-1:0]  result_1_i,
    input  logic [DWIDTH-1:0]  result_2_i,
    input  logic [DWIDTH-1:0]  result_3_i,
    output logic               idle_o,
    output logic               write_o,
    output logic               done_o,
    output logic [AWIDTH-1:0]  addr_b2_o,
    output logic               ce_b2_o,
    output logic               we_b2_o,
    output logic [DWIDTH-1:0]  d_b2_o
);

`ifdef RESULT_WRITER_PACK8_EN
    localparam bit PACK_EN = 1'b1;
`else
    localparam bit PACK_EN = 1'b0;
`endif
    localparam int WCW = CNT_BIT + 2;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
    typedef logic [3:0][DWIDTH-1:0] entry_t;

    state_t             state_q, state_d;
    logic [CNT_BIT-1:0] num_cnt_q, num_cnt_d;
    logic [CNT_BIT-1:0] acc_cnt_q, acc_cnt_d;
    logic [WCW-1:0]     word_cnt_q, word_cnt_d;
    logic [AWIDTH-1:0]  base_q, base_d;
    logic [1:0]         lane_q, lane_d;
    logic [1:0]         fifo_cnt_q, fifo_cnt_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    entry_t             fifo_mem_q [2];
    entry_t             fifo_mem_d [2];
    logic               ce_q, ce_d;
    logic [AWIDTH-1:0]  addr_q, addr_d;
    logic [DWIDTH-1:0]  dout_q, dout_d;

    logic                       push, emit, pop;
    entry_t                     head_entry;
    logic [WCW-1:0]             total_words;
    logic [DWIDTH-1:0]          word_data;
    logic [4*IN_DATA_WIDTH-1:0] packed_word;

    assign result_ready_o = (state_q == S_RUN) && (fifo_cnt_q < 2'd2) && (acc_cnt_q < num_cnt_q);
    assign push        = result_valid_i && result_ready_o;
    assign head_entry  = fifo_mem_q[rd_ptr_q];
    assign emit        = (state_q == S_RUN) && (fifo_cnt_q != 2'd0);
    assign pop         = emit && (PACK_EN || (lane_q == 2'd3));
    assign total_words = PACK_EN ? {2'b00, num_cnt_q} : {num_cnt_q, 2'b00};

    // Lane 0 lands in the most significant byte of the packed word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_clamp
            assign packed_word[(3-gi)*IN_DATA_WIDTH +: IN_DATA_WIDTH] =
                (|head_entry[gi][DWIDTH-1:IN_DATA_WIDTH]) ? {IN_DATA_WIDTH{1'b1}}
                                                           : head_entry[gi][IN_DATA_WIDTH-1:0];
        end
    endgenerate

    assign word_data = PACK_EN ? DWIDTH'(packed_word) : head_entry[lane_q];

    always_comb begin
        state_d    = state_q;
        num_cnt_d  = num_cnt_q;
        acc_cnt_d  = acc_cnt_q;
        word_cnt_d = word_cnt_q;
        base_d     = base_q;
        lane_d     = lane_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_mem_d = fifo_mem_q;
        ce_d       = 1'b0;
        addr_d     = addr_q;
        dout_d     = dout_q;
        case (state_q)
            S_IDLE: begin
                if (start_run_i) begin
                    state_d    = S_RUN;
                    num_cnt_d  = run_count_i;
                    base_d     = base_addr_i;
                    acc_cnt_d  = '0;
                    word_cnt_d = '0;
                    lane_d     = 2'd0;
                    fifo_cnt_d = 2'd0;
                    wr_ptr_d   = 1'b0;
                    rd_ptr_d   = 1'b0;
                end
            end
            S_RUN: begin
                // Finishing one cycle after the last write also covers a zero-beat run.
                if (word_cnt_q == total_words) begin
                    state_d = S_DONE;
                end else begin
                    if (push) begin
                        fifo_mem_d[wr_ptr_q] = {result_3_i, result_2_i, result_1_i, result_0_i};
                        wr_ptr_d  = ~wr_ptr_q;
                        acc_cnt_d = acc_cnt_q + CNT_BIT'(1);
                    end
                    if (emit) begin
                        ce_d       = 1'b1;
                        addr_d     = base_q + word_cnt_q[AWIDTH-1:0];
                        dout_d     = word_data;
                        word_cnt_d = word_cnt_q + WCW'(1);
                        lane_d     = pop ? 2'd0 : lane_q + 2'd1;
                        if (pop) begin
                            rd_ptr_d = ~rd_ptr_q;
                        end
                    end
                    case ({push, pop})
                        2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
                        2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
                        default: fifo_cnt_d = fifo_cnt_q;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            num_cnt_q  <= '0;
            acc_cnt_q  <= '0;
            word_cnt_q <= '0;
            base_q     <= '0;
            lane_q     <= 2'd0;
            fifo_cnt_q <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            ce_q       <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            num_cnt_q  <= num_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
            word_cnt_q <= word_cnt_d;
            base_q     <= base_d;
            lane_q     <= lane_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ce_q       <= ce_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign idle_o    = (state_q == S_IDLE);
    assign write_o   = (state_q == S_RUN);
    assign done_o    = (state_q == S_DONE);
    assign addr_b2_o = addr_q;
    assign ce_b2_o   = ce_q;
    assign we_b2_o   = ce_q;
    assign d_b2_o    = dout_q;

endmodule

// File: tb/tb_result_writer_bram.sv
// Directed self-checking bench for result_writer_bram: one task per scenario.
module tb_result_writer_bram;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_run_i = 1'b0;
    logic [30:0] run_count_i = '0;
    logic [11:0] base_addr_i = '0;
    logic        result_valid_i = 1'b0;
    logic        result_ready_o;
    logic [31:0] result_0_i = '0, result_1_i = '0, result_2_i = '0, result_3_i = '0;
    logic        idle_o, write_o, done_o;
    logic [11:0] addr_b2_o;
    logic        ce_b2_o, we_b2_o;
    logic [31:0] d_b2_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [11:0] wq_addr [$];
    logic [31:0] wq_data [$];
    int          wq_cyc  [$];
    int          we_bad = 0;
    int          done_cnt = 0;
    bit          ready_seen = 1'b0;

    result_writer_bram dut (
        .clk(clk), .reset(reset), .start_run_i(start_run_i), .run_count_i(run_count_i),
        .base_addr_i(base_addr_i), .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
        .result_0_i(result_0_i), .result_1_i(result_1_i), .result_2_i(result_2_i), .result_3_i(result_3_i),
        .idle_o(idle_o), .write_o(write_o), .done_o(done_o), .addr_b2_o(addr_b2_o),
        .ce_b2_o(ce_b2_o), .we_b2_o(we_b2_o), .d_b2_o(d_b2_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ce_b2_o || we_b2_o) begin
            wq_addr.push_back(addr_b2_o);
            wq_data.push_back(d_b2_o);
            wq_cyc.push_back(cyc);
            if (!(ce_b2_o && we_b2_o)) we_bad++;
            $display("write cyc=%0d addr=0x%03h data=0x%08h ce=%0b we=%0b", cyc, addr_b2_o, d_b2_o, ce_b2_o, we_b2_o);
        end
        if (done_o) done_cnt++;
        if (result_ready_o) ready_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic clear_mon();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        we_bad = 0; done_cnt = 0; ready_seen = 1'b0;
    endtask

    task automatic start_run(input logic [30:0] cnt, input logic [11:0] base);
        @(posedge clk); #1;
        start_run_i = 1'b1; run_count_i = cnt; base_addr_i = base;
        @(posedge clk); #1;
        start_run_i = 1'b0;
        $display("start count=%0d base=0x%03h", cnt, base);
    endtask

    task automatic send_beat(input logic [31:0] a, b, c, d, output int acc_cyc);
        result_0_i = a; result_1_i = b; result_2_i = c; result_3_i = d;
        result_valid_i = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (result_ready_o) begin
                @(posedge clk); #1;
                acc_cyc = cyc;
                break;
            end
        end
        result_valid_i = 1'b0;
        checks++;
        if (acc_cyc < 0) begin
            failures++;
            $display("FAIL beat_accept timeout: got no accept, want accept within 100 cycles");
        end else begin
            $display("beat accepted cyc=%0d lanes=%0h,%0h,%0h,%0h", acc_cyc, a, b, c, d);
        end
    endtask

    task automatic wait_idle(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (idle_o) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_idle timeout: idle_o=%0b want 1 within %0d cycles", idle_o, bound);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({idle_o, write_o, done_o, result_ready_o, ce_b2_o, we_b2_o} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 100000", {idle_o, write_o, done_o, result_ready_o, ce_b2_o, we_b2_o});
        end
        checks++;
        if (addr_b2_o !== 12'h000 || d_b2_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: addr=%h d=%h want 0/0", addr_b2_o, d_b2_o);
        end
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        checks++;
        if (idle_o !== 1'b1 || result_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: idle=%0b ready=%0b want 1/0", idle_o, result_ready_o);
        end
    endtask

    task automatic test_single_beat();
        int acc;
        clear_mon();
        start_run(31'd1, 12'h010);
        send_beat(32'd1, 32'd2, 32'd3, 32'd4, acc);
        wait_idle(50);
        checks++;
        if (wq_addr.size() != 4) begin
            failures++;
            $display("FAIL single_count: got %0d writes want 4", wq_addr.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wq_addr[k] !== 12'h010 + 12'(k) || wq_data[k] !== 32'(k + 1) || wq_cyc[k] != acc + 1 + k) begin
                    failures++;
                    $display("FAIL single_word%0d: addr=%h data=%h cyc=%0d want %h/%h/%0d",
                             k, wq_addr[k], wq_data[k], wq_cyc[k], 12'h010 + 12'(k), k + 1, acc + 1 + k);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || we_bad != 0 || idle_o !== 1'b1) begin
            failures++;
            $display("FAIL single_done: done_pulses=%0d ce_we_mismatch=%0d idle=%0b want 1/0/1", done_cnt, we_bad, idle_o);
        end
    endtask

    task automatic test_burst_backpressure();
        int acc [4];
        int idx = 0;
        bit rdy;
        clear_mon();
        start_run(31'd4, 12'h100);
        result_valid_i = 1'b1;
        result_0_i = 32'hB000_0000; result_1_i = 32'hB000_0001;
        result_2_i = 32'hB000_0002; result_3_i = 32'hB000_0003;
        for (int i = 0; i < 200 && idx < 4; i++) begin
            @(negedge clk);
            rdy = result_ready_o;
            @(posedge clk); #1;
            if (rdy) begin
                acc[idx] = cyc;
                $display("burst beat %0d accepted cyc=%0d", idx, cyc);
                idx++;
                result_0_i = 32'hB000_0000 + 32'(idx * 16);
                result_1_i = 32'hB000_0001 + 32'(idx * 16);
                result_2_i = 32'hB000_0002 + 32'(idx * 16);
                result_3_i = 32'hB000_0003 + 32'(idx * 16);
            end
        end
        result_valid_i = 1'b0;
        checks++;
        if (idx != 4) begin
            failures++;
            $display("FAIL burst_accepts: got %0d want 4", idx);
        end else begin
            checks++;
            if (acc[1] - acc[0] != 1 || acc[2] - acc[1] != 4 || acc[3] - acc[2] != 4) begin
                failures++;
                $display("FAIL burst_ready_spacing: got %0d,%0d,%0d want 1,4,4",
                         acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2]);
            end
        end
        wait_idle(100);
        checks++;
        if (wq_addr.size() != 16) begin
            failures++;
            $display("FAIL burst_count: got %0d writes want 16", wq_addr.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (wq_addr[k] !== 12'h100 + 12'(k) ||
                    wq_data[k] !== 32'hB000_0000 + 32'((k / 4) * 16 + (k % 4)) ||
                    wq_cyc[k] != acc[0] + 1 + k) begin
                    failures++;
                    $display("FAIL burst_word%0d: addr=%h data=%h cyc=%0d want %h/%h/%0d", k, wq_addr[k], wq_data[k],
                             wq_cyc[k], 12'h100 + 12'(k), 32'hB000_0000 + 32'((k / 4) * 16 + (k % 4)), acc[0] + 1 + k);
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL burst_done: got %0d done pulses want 1", done_cnt);
        end
    endtask

    task automatic test_zero_count();
        clear_mon();
        start_run(31'd0, 12'h050);
        @(negedge clk);
        checks++;
        if ({idle_o, write_o, done_o, result_ready_o} !== 4'b0100) begin
            failures++;
            $display("FAIL zero_run_cycle: idle/write/done/ready=%b want 0100", {idle_o, write_o, done_o, result_ready_o});
        end
        @(negedge clk);
        checks++;
        if ({idle_o, write_o, done_o} !== 3'b001) begin
            failures++;
            $display("FAIL zero_done_cycle: idle/write/done=%b want 001", {idle_o, write_o, done_o});
        end
        @(negedge clk);
        checks++;
        if ({idle_o, write_o, done_o} !== 3'b100) begin
            failures++;
            $display("FAIL zero_idle_cycle: idle/write/done=%b want 100", {idle_o, write_o, done_o});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wq_addr.size() != 0 || ready_seen || done_cnt != 1) begin
            failures++;
            $display("FAIL zero_quiet: writes=%0d ready_seen=%0b done=%0d want 0/0/1", wq_addr.size(), ready_seen, done_cnt);
        end
    endtask

    task automatic test_overrun_ignored_start();
        int accepts = 0;
        bit rdy;
        clear_mon();
        start_run(31'd2, 12'h200);
        result_valid_i = 1'b1;
        result_0_i = 32'hC000_0000; result_1_i = 32'hC000_0001;
        result_2_i = 32'hC000_0002; result_3_i = 32'hC000_0003;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            rdy = result_ready_o;
            @(posedge clk); #1;
            if (i == 2) begin
                start_run_i = 1'b1; run_count_i = 31'd5; base_addr_i = 12'h300;
            end else begin
                start_run_i = 1'b0;
            end
            if (rdy && accepts < 3) begin
                accepts++;
                result_0_i = 32'hC000_0000 + 32'(accepts * 16);
                result_1_i = 32'hC000_0001 + 32'(accepts * 16);
                result_2_i = 32'hC000_0002 + 32'(accepts * 16);
                result_3_i = 32'hC000_0003 + 32'(accepts * 16);
            end
        end
        result_valid_i = 1'b0;
        wait_idle(20);
        checks++;
        if (accepts != 2) begin
            failures++;
            $display("FAIL overrun_accepts: got %0d want 2", accepts);
        end
        checks++;
        if (wq_addr.size() != 8) begin
            failures++;
            $display("FAIL overrun_count: got %0d writes want 8", wq_addr.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (wq_addr[k] !== 12'h200 + 12'(k) || wq_data[k] !== 32'hC000_0000 + 32'((k / 4) * 16 + (k % 4))) begin
                    failures++;
                    $display("FAIL overrun_word%0d: addr=%h data=%h want %h/%h", k, wq_addr[k], wq_data[k],
                             12'h200 + 12'(k), 32'hC000_0000 + 32'((k / 4) * 16 + (k % 4)));
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL overrun_done: got %0d done pulses want 1", done_cnt);
        end
    endtask

    task automatic test_wrap();
        int acc;
        logic [11:0] exp_addr [4];
        exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000; exp_addr[3] = 12'h001;
        clear_mon();
        start_run(31'd1, 12'hFFE);
        send_beat(32'hA0, 32'hA1, 32'hA2, 32'hA3, acc);
        wait_idle(50);
        checks++;
        if (wq_addr.size() != 4) begin
            failures++;
            $display("FAIL wrap_count: got %0d writes want 4", wq_addr.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wq_addr[k] !== exp_addr[k] || wq_data[k] !== 32'hA0 + 32'(k)) begin
                    failures++;
                    $display("FAIL wrap_word%0d: addr=%h data=%h want %h/%h", k, wq_addr[k], wq_data[k], exp_addr[k], 32'hA0 + 32'(k));
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int acc;
        clear_mon();
        start_run(31'd2, 12'h040);
        send_beat(32'h11, 32'h22, 32'h33, 32'h44, acc);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({we_b2_o, ce_b2_o, idle_o, write_o, result_ready_o} !== 5'b00100) begin
            failures++;
            $display("FAIL midreset_flags: we/ce/idle/write/ready=%b want 00100", {we_b2_o, ce_b2_o, idle_o, write_o, result_ready_o});
        end
        checks++;
        if (addr_b2_o !== 12'h000 || d_b2_o !== 32'h0 || wq_addr.size() != 1) begin
            failures++;
            $display("FAIL midreset_bus: addr=%h d=%h writes=%0d want 0/0/1", addr_b2_o, d_b2_o, wq_addr.size());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        clear_mon();
        start_run(31'd1, 12'h080);
        send_beat(32'd9, 32'd8, 32'd7, 32'd6, acc);
        wait_idle(50);
        checks++;
        if (wq_addr.size() != 4 || done_cnt != 1) begin
            failures++;
            $display("FAIL clean_restart_count: writes=%0d done=%0d want 4/1", wq_addr.size(), done_cnt);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wq_addr[k] !== 12'h080 + 12'(k) || wq_data[k] !== 32'(9 - k) || wq_cyc[k] != acc + 1 + k) begin
                    failures++;
                    $display("FAIL clean_restart_word%0d: addr=%h data=%h cyc=%0d want %h/%h/%0d", k, wq_addr[k], wq_data[k],
                             wq_cyc[k], 12'h080 + 12'(k), 9 - k, acc + 1 + k);
                end
            end
        end
    endtask

    task automatic test_pack8();
        int acc;
        clear_mon();
        start_run(31'd1, 12'h020);
        send_beat(32'd300, 32'd255, 32'd7, 32'd0, acc);
        wait_idle(50);
        checks++;
        if (wq_addr.size() != 1) begin
            failures++;
            $display("FAIL pack8_count: got %0d writes want 1", wq_addr.size());
        end else begin
            checks++;
            if (wq_addr[0] !== 12'h020 || wq_data[0] !== 32'hFFFF_0700 || wq_cyc[0] != acc + 1) begin
                failures++;
                $display("FAIL pack8_word: addr=%h data=%h cyc=%0d want 020/ffff0700/%0d", wq_addr[0], wq_data[0], wq_cyc[0], acc + 1);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
`ifdef RESULT_WRITER_PACK8_EN
        test_pack8();
`else
        test_single_beat();
        test_burst_backpressure();
        test_zero_count();
        test_overrun_ignored_start();
        test_wrap();
        test_reset_mid_run();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_writer_bram.md
Name: result_writer_bram

Overview:
- Write-side counterpart of the BRAM read/MAC data mover.
- Accepts 4-lane core result beats (result_0..3 plus valid) through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Serialises each beat into 4 consecutive 32-bit writes on the result BRAM (BRAM2) port.
- Reports idle/write/done status to the register block, with the same status semantics as the read mover.

Parameters:
- CNT_BIT, 31, width of run_count_i and the beat counters.
- DWIDTH, 32, BRAM word and result lane width.
- AWIDTH, 12, BRAM2 address width.
- IN_DATA_WIDTH, 8, packed lane width (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- start_run_i  in  1  start pulse; sampled only in IDLE.
- run_count_i  in  CNT_BIT  number of result beats to write; captured on start.
- base_addr_i  in  AWIDTH  first BRAM2 address; captured on start.
- result_valid_i  in  1  result beat valid.
- result_ready_o  out  1  writer can accept a beat.
- result_0_i..result_3_i  in  DWIDTH each  lane results; lane 0 is written first.
- idle_o / write_o / done_o  out  1 each  state flags.
- addr_b2_o  out  AWIDTH  BRAM2 address.
- ce_b2_o  out  1  BRAM2 chip enable.
- we_b2_o  out  1  BRAM2 write enable.
- d_b2_o  out  DWIDTH  BRAM2 write data.

Behaviour:
- Reset, synchronous, applies at any time including mid-run:
  - state to IDLE; FIFO emptied; all counters to 0.
  - idle_o=1; write_o, done_o, result_ready_o, ce_b2_o, we_b2_o = 0; addr_b2_o=0; d_b2_o=0.
  - Buffered beats are discarded.
- FSM states and transitions:
  - IDLE→RUN on start_run_i; num_cnt<=run_count_i and base<=base_addr_i.
  - RUN→DONE in the cycle after the final word write (write cycle with word count == 4*num_cnt-1).
  - RUN→DONE one cycle after entry if num_cnt==0.
  - DONE→IDLE unconditionally; done_o is a 1-cycle pulse.
  - start_run_i is ignored outside IDLE.
- Handshake:
  - Beat is accepted when result_valid_i && result_ready_o.
  - result_ready_o = (state==RUN) && (fifo_count<2) && (accepted_cnt<num_cnt). It is combinational from registered state.
  - A valid beat that is not accepted is held by the producer; its data must stay stable.
  - Once accepted_cnt==num_cnt, ready stays low; extra beats are never taken.
- FIFO: 2 entries of 4×DWIDTH. A push and a pop in the same cycle are both legal.
- Serialiser:
  - Head entry is written one lane per cycle: lane k at address base + 4*beat_idx + k, where beat_idx is the entry's accepted order.
  - ce_b2_o = we_b2_o = 1 in each write cycle; addr and d are registered outputs.
  - Head is popped in the cycle its lane 3 is written.
  - No idle cycle between consecutive buffered entries.
- Latency: beat accepted at edge N → lane 0 write asserted on ce/we in cycle N+1. Lanes 1..3 follow in cycles N+2..N+4.
- Throughput: sustained 1 beat per 4 cycles; bursts of 2 back-to-back beats are absorbed.
- Address arithmetic is modulo 2^AWIDTH; wrap past 2^AWIDTH-1 is silent.
- write_o = (state==RUN). idle_o = (state==IDLE).

Optional Feature:
- Macro: RESULT_WRITER_PACK8_EN.
- Defined:
  - Each lane is clamped unsigned to [0, 2^IN_DATA_WIDTH-1].
  - The 4 clamped values are packed into one word: lane0 in bits [31:24] … lane3 in bits [7:0].
  - Each beat produces one write at base + beat_idx, 1 cycle after accept.
  - Total writes = num_cnt; throughput 1 beat/cycle.
- Undefined: 4 unpacked writes per beat, as described above.

Test Plan:
- Single beat:
  - Stimulus: start, run_count=1, base=0x010, beat {1,2,3,4}.
  - Response: writes 0x010..0x013 = 1,2,3,4 on consecutive cycles, first write 1 cycle after accept; done_o pulses once, then idle_o=1.
- Burst backpressure:
  - Stimulus: run_count=4, valid held high continuously.
  - Response: ready drops after 2 accepts and re-asserts as entries drain; 16 writes to base..base+15, in order, no gaps.
- Zero count:
  - Stimulus: run_count=0.
  - Response: RUN 1 cycle, DONE 1 cycle, no ce/we; result_ready_o never 1.
- Overrun and ignored start:
  - Stimulus: run_count=2, 3 valid beats offered, start_run_i pulsed during RUN.
  - Response: only 2 accepted, 8 writes; the restart has no effect.
- Wrap and reset:
  - Stimulus: base=0xFFE, run_count=1.
  - Response: writes land at 0xFFE, 0xFFF, 0x000, 0x001.
  - Stimulus: reset asserted mid-serialisation.
  - Response: we_b2_o=0 on the next cycle, idle_o=1, a later run starts clean.
- PACK8 (macro defined):
  - Stimulus: beat {300, 255, 7, 0}.
  - Response: single write of 0xFFFF0700 at base.
